controlpath: RTL and testbench
==============================

CONTROLPATH -- requirements
Module: controlpath

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port: N  input  1  ALU negative flag from the datapath.
REQ-004 SHALL have port: Z  input  1  ALU zero flag from the datapath.
REQ-005 SHALL have port: MBR  input  8  memory byte register (opcode) for dispatch.
REQ-006 SHALL have port: MIR  input  12 (bits [35:24])  microinstruction control field.
REQ-007 SHALL have port: MPC  output  9  microprogram counter (next control-store address), registered.
REQ-008 SHALL decode MIR fields as:
- NEXT_ADDRESS = MIR[35:27], 9 bits
- JMPC = MIR[26]
- JAMN = MIR[25]
- JAMZ = MIR[24]
REQ-009 SHALL have no parameters; all widths are fixed as listed.

Function
REQ-010 SHALL hold internal flag registers N_s and Z_s, loaded from N and Z on every rising clk edge.
REQ-011 SHALL compute high_bit = (JAMZ AND Z_s) OR (JAMN AND N_s) OR NEXT_ADDRESS[8].
- Uses the registered flags, not the live N/Z inputs.
REQ-012 SHALL select the low byte by JMPC:
- JMPC = 1 (direct): low = NEXT_ADDRESS[7:0]
- JMPC = 0 (dispatch): low = NEXT_ADDRESS[7:0] bitwise-OR MBR
REQ-013 SHALL load MPC <= {high_bit, low} on every rising clk edge while rst is high.
REQ-014 SHALL read MIR and MBR combinationally at the clock edge.
- MIR/MBR change -> MPC reflects it after 1 rising edge.
- N/Z change -> effect on MPC after 2 rising edges (flag register, then MPC).
REQ-015 SHALL never let N/Z affect MPC when the corresponding JAMN/JAMZ bit is 0.
REQ-016 SHALL have NEXT_ADDRESS[8] = 1 force MPC[8] = 1 regardless of flags.
REQ-017 SHALL leave MPC[8] unaffected by MBR; MBR ORs into bits [7:0] only.
REQ-018 SHALL keep MPC stable between rising edges; no combinational path from any input to MPC.

Reset
REQ-019 SHALL, while rst = 0, immediately (asynchronously, without a clock edge) force MPC = 9'h000, N_s = 0, Z_s = 0.
REQ-020 SHALL hold these reset values for as long as rst stays low, regardless of clk or other inputs.
REQ-021 SHALL, on the first rising edge after rst returns high, compute MPC per REQ-013 using the cleared flags.
REQ-022 SHALL, on reset asserted mid-operation, discard any pending flag value; no flag carries over across reset.

Verification
REQ-023 SHALL pass: rst = 0 with arbitrary inputs -> MPC = 0 immediately; stays 0 while rst is low.
REQ-024 SHALL pass: rst = 1, MIR = {9'h1FF, JMPC = 1, JAMN = 0, JAMZ = 0}, MBR = 0, N = Z = 0 -> after 1 edge MPC = 9'h1FF.
REQ-025 SHALL pass: NEXT_ADDRESS = 0, JMPC = 1, JAMN = 1, N = 1, Z = 0 ->
- MPC = 9'h000 after edge 1
- MPC = 9'h100 after edge 2
REQ-026 SHALL pass: NEXT_ADDRESS = 9'h0F0, JMPC = 0, MBR = 8'h55, flags 0 -> MPC = 9'h0F5.
REQ-027 SHALL pass: NEXT_ADDRESS = 9'h0F0, JMPC = 0, JAMZ = 1, Z = 1, MBR = 8'h55 -> MPC = 9'h1F5 after 2 edges.
REQ-028 SHALL pass: same as REQ-027 but JAMZ = 0 -> MPC stays 9'h0F5; Z is ignored.

Source files
------------

// File: rtl/controlpath.sv
// Microsequencer: next-address logic for a microprogrammed control unit.
// Registers the ALU flags, then forms the next MPC from MIR jump bits and MBR dispatch.
module controlpath (
   input  logic         clk,
   input  logic         rst,
   input  logic         N,
   input  logic         Z,
   input  logic [7:0]   MBR,
   input  logic [35:24] MIR,
   output logic [8:0]   MPC
);

   logic [8:0] w_next_addr;
   logic       w_jmpc;
   logic       w_jamn;
   logic       w_jamz;
   logic       w_high_bit;
   logic [7:0] w_low;

   logic       r_n;
   logic       r_z;
   logic [8:0] r_mpc;

   assign w_next_addr = MIR[35:27];
   assign w_jmpc      = MIR[26];
   assign w_jamn      = MIR[25];
   assign w_jamz      = MIR[24];

   // Jam conditions use the flags captured on the previous edge, not the live ALU outputs.
   always_comb begin
      w_high_bit = (w_jamz & r_z) | (w_jamn & r_n) | w_next_addr[8];
      w_low      = w_next_addr[7:0];
      if (!w_jmpc) begin
         w_low = w_next_addr[7:0] | MBR;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_n   <= 1'b0;
         r_z   <= 1'b0;
         r_mpc <= '0;
      end else begin
         r_n   <= N;
         r_z   <= Z;
         r_mpc <= {w_high_bit, w_low};
      end
   end

   assign MPC = r_mpc;

endmodule

// File: tb/tb_controlpath.sv
// Directed-vector bench for controlpath: reset behaviour, direct/dispatch addressing,
// registered-flag jam timing and flag clearing across reset.
module tb_controlpath;

   logic         clk;
   logic         rst;
   logic         N;
   logic         Z;
   logic [7:0]   MBR;
   logic [35:24] MIR;
   logic [8:0]   MPC;

   int unsigned checks;
   int unsigned errors;

   controlpath u_dut (
      .clk (clk),
      .rst (rst),
      .N   (N),
      .Z   (Z),
      .MBR (MBR),
      .MIR (MIR),
      .MPC (MPC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic set_mir(input logic [8:0] na, input logic jmpc, input logic jamn, input logic jamz);
      MIR = {na, jmpc, jamn, jamz};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // Reset asserted from time zero with arbitrary inputs
      rst = 1'b0;
      N   = 1'b1;
      Z   = 1'b1;
      MBR = 8'hA5;
      set_mir(9'h1FF, 1'b0, 1'b1, 1'b1);
      #1;
      check_val("reset_immediate", MPC, 9'h000);
      tick();
      check_val("reset_hold_1", MPC, 9'h000);
      MBR = 8'h3C;
      set_mir(9'h155, 1'b1, 1'b1, 1'b0);
      tick();
      check_val("reset_hold_2", MPC, 9'h000);

      // Direct jump to all-ones address
      N   = 1'b0;
      Z   = 1'b0;
      MBR = 8'h00;
      set_mir(9'h1FF, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      check_val("direct_1ff", MPC, 9'h1FF);

      // JAMN: flag takes two edges to reach MPC
      set_mir(9'h000, 1'b1, 1'b1, 1'b0);
      N = 1'b1;
      tick();
      check_val("jamn_edge1", MPC, 9'h000);
      tick();
      check_val("jamn_edge2", MPC, 9'h100);

      // Dispatch OR of MBR, jams off
      N   = 1'b0;
      MBR = 8'h55;
      set_mir(9'h0F0, 1'b0, 1'b0, 1'b0);
      tick();
      check_val("dispatch_0f5", MPC, 9'h0F5);

      // JAMZ with Z
      set_mir(9'h0F0, 1'b0, 1'b0, 1'b1);
      Z = 1'b1;
      tick();
      check_val("jamz_edge1", MPC, 9'h0F5);
      tick();
      check_val("jamz_edge2", MPC, 9'h1F5);

      // Z ignored when JAMZ = 0
      set_mir(9'h0F0, 1'b0, 1'b0, 1'b0);
      tick();
      check_val("nojamz_1", MPC, 9'h0F5);
      N = 1'b1;
      tick();
      check_val("nojam_flags_set", MPC, 9'h0F5);

      // NEXT_ADDRESS[8] forces MPC[8] with flags clear
      N = 1'b0;
      Z = 1'b0;
      set_mir(9'h100, 1'b1, 1'b0, 1'b0);
      tick();
      check_val("na8_force", MPC, 9'h100);

      // MBR never reaches bit 8
      MBR = 8'hFF;
      set_mir(9'h000, 1'b0, 1'b0, 1'b0);
      tick();
      check_val("mbr_low_only", MPC, 9'h0FF);

      // Direct mode ignores MBR
      set_mir(9'h012, 1'b1, 1'b0, 1'b0);
      tick();
      check_val("direct_ignores_mbr", MPC, 9'h012);

      // Both jams set, only N true
      N   = 1'b1;
      Z   = 1'b0;
      MBR = 8'h0A;
      set_mir(9'h020, 1'b0, 1'b1, 1'b1);
      tick();
      check_val("both_jam_edge1", MPC, 9'h02A);
      tick();
      check_val("both_jam_edge2", MPC, 9'h12A);

      // Mid-operation reset clears captured flags
      N = 1'b1;
      Z = 1'b1;
      set_mir(9'h000, 1'b1, 1'b1, 1'b1);
      tick();
      check_val("pre_reset_jam", MPC, 9'h100);
      #2;
      rst = 1'b0;
      #1;
      check_val("midop_reset_async", MPC, 9'h000);
      tick();
      check_val("midop_reset_hold", MPC, 9'h000);
      N   = 1'b0;
      Z   = 1'b0;
      rst = 1'b1;
      tick();
      check_val("flags_cleared_after_reset", MPC, 9'h000);
      tick();
      check_val("flags_stay_clear", MPC, 9'h000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
